// File: rtl/fifo_drain.sv
// Drains an upstream FIFO (1-cycle read latency) into a 2-entry in-order skid
// buffer that feeds a valid/ready consumer. Counts delivered words.
module fifo_drain #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic                  FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0] FIFO_DATA,
    output logic                  READ,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  VALID_OUT,
    input  logic                  READY_IN,
    output logic                  BUSY,
    output logic [15:0]           XFER_CNT
);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

    state_t                state, state_nxt;
    logic [1:0]            occ;
    logic                  inf;
    logic [DATA_WIDTH-1:0] ent0, ent1;
    logic [15:0]           cnt;
    logic                  pop, rd, cap;
    logic [2:0]            load;

    assign VALID_OUT = ~RESET & (occ != 2'd0);
    assign pop       = VALID_OUT & READY_IN;
    assign cap       = inf;

    // Slots committed one cycle from now; pop implies occ >= 1, so no underflow.
    assign load = {1'b0, occ} + {2'b00, inf} - {2'b00, pop};
    assign rd   = (state == ACTIVE) & ENABLE & ~FIFO_EMPTY & (load < 3'd2);

    assign READ     = rd & ~RESET;
    assign DATA_OUT = RESET ? '0 : ent0;
    assign BUSY     = ~RESET & (state != IDLE);
    assign XFER_CNT = RESET ? 16'd0 : cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ENABLE) state_nxt = ACTIVE;
            ACTIVE:  if (!ENABLE) state_nxt = ((occ != 2'd0) || inf) ? FLUSH : IDLE;
            FLUSH: begin
                if (ENABLE)
                    state_nxt = ACTIVE;
                else if ((occ == 2'd0) && !inf)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            inf   <= 1'b0;
            cnt   <= 16'd0;
        end else begin
            state <= state_nxt;
            inf   <= rd;
            if (pop)
                cnt <= cnt + 16'd1;
        end
    end

    // ent0 is always the oldest word; ent1 only holds data when occ == 2.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            occ  <= 2'd0;
            ent0 <= '0;
            ent1 <= '0;
        end else begin
            case ({cap, pop})
                2'b11: begin
                    if (occ == 2'd2) begin
                        ent0 <= ent1;
                        ent1 <= FIFO_DATA;
                    end else begin
                        ent0 <= FIFO_DATA;
                    end
                end
                2'b01: begin
                    ent0 <= ent1;
                    occ  <= occ - 2'd1;
                end
                2'b10: begin
                    if (occ == 2'd0)
                        ent0 <= FIFO_DATA;
                    else
                        ent1 <= FIFO_DATA;
                    occ <= occ + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: emulated upstream FIFO, queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_fifo_drain;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        ENABLE = 1'b0;
    logic        FIFO_EMPTY = 1'b1;
    logic [7:0]  FIFO_DATA = 8'h00;
    logic        READ;
    logic [7:0]  DATA_OUT;
    logic        VALID_OUT;
    logic        READY_IN = 1'b0;
    logic        BUSY;
    logic [15:0] XFER_CNT;

    fifo_drain #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_DATA(FIFO_DATA), .READ(READ), .DATA_OUT(DATA_OUT),
        .VALID_OUT(VALID_OUT), .READY_IN(READY_IN), .BUSY(BUSY), .XFER_CNT(XFER_CNT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: buffered words as a queue, one in-flight bit, spec FSM.
    localparam int S_IDLE = 0, S_ACT = 1, S_FLUSH = 2;
    logic [7:0] mq[$];
    bit         m_inf = 1'b0;
    int         m_state = S_IDLE;
    int         m_cnt = 0;

    always @(negedge CLK) begin : cmp
        int occ;
        bit e_valid, e_pop, e_read, e_busy;
        logic [15:0] e_cnt;
        occ = mq.size();
        if (RESET) begin
            e_valid = 0; e_pop = 0; e_read = 0; e_busy = 0; e_cnt = 16'd0;
        end else begin
            e_valid = occ > 0;
            e_pop   = e_valid && READY_IN;
            e_read  = (m_state == S_ACT) && ENABLE && !FIFO_EMPTY && (occ + m_inf - e_pop < 2);
            e_busy  = m_state != S_IDLE;
            e_cnt   = 16'(m_cnt % 65536);
        end
        chk("m_read", READ, e_read);
        chk("m_valid", VALID_OUT, e_valid);
        chk("m_busy", BUSY, e_busy);
        chk("m_cnt", XFER_CNT, e_cnt);
        if (RESET) chk("m_data_rst", DATA_OUT, 0);
        else if (e_valid) chk("m_data", DATA_OUT, mq[0]);

        if (RESET) begin
            mq.delete(); m_inf = 0; m_state = S_IDLE; m_cnt = 0;
        end else begin
            case (m_state)
                S_IDLE:  if (ENABLE) m_state = S_ACT;
                S_ACT:   if (!ENABLE) m_state = (occ > 0 || m_inf) ? S_FLUSH : S_IDLE;
                default: if (ENABLE) m_state = S_ACT;
                         else if (occ == 0 && !m_inf) m_state = S_IDLE;
            endcase
            if (e_pop) begin void'(mq.pop_front()); m_cnt++; end
            if (m_inf) mq.push_back(FIFO_DATA);
            m_inf = e_read;
        end
    end

    // Upstream FIFO emulation and sampled observations for directed checks.
    logic [7:0] fifo_q[$];
    logic [7:0] got[$];
    bit         s_read = 0, s_valid = 0, s_busy = 0;
    logic [7:0] s_data;
    logic [15:0] s_cnt;
    int         rd_cnt = 0;
    logic [7:0] pat[5];
    logic [7:0] w8[8];

    task automatic step(input bit en, input bit rdy, input bit rst);
        @(posedge CLK);
        #1;
        if (s_read && fifo_q.size() > 0) FIFO_DATA = fifo_q.pop_front();
        else FIFO_DATA = 8'($urandom);
        FIFO_EMPTY = (fifo_q.size() == 0);
        ENABLE = en; READY_IN = rdy; RESET = rst;
        #3;
        s_read = READ; s_valid = VALID_OUT; s_data = DATA_OUT; s_busy = BUSY; s_cnt = XFER_CNT;
        if (s_valid && READY_IN) got.push_back(s_data);
        if (s_read) rd_cnt++;
    endtask

    task automatic do_reset();
        fifo_q.delete();
        step(0, 0, 1);
        step(0, 0, 1);
        got.delete();
        rd_cnt = 0;
    endtask

    task automatic load5();
        for (int k = 0; k < 5; k++) fifo_q.push_back(pat[k]);
    endtask

    initial begin
        bit rdv[10], vv[10];
        logic [7:0] dv[10];
        int unstable, delivered, gaps, pushed;
        bit started;
        pat = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        w8  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h5A, 8'hC3};

        // reset state and streaming
        do_reset();
        chk("rst_read", s_read, 0);
        chk("rst_valid", s_valid, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_cnt", s_cnt, 0);
        chk("rst_data", s_data, 0);
        load5();
        for (int c = 0; c < 10; c++) begin
            step(1, 1, 0);
            rdv[c] = s_read; vv[c] = s_valid; dv[c] = s_data;
        end
        for (int c = 0; c < 8; c++) chk("stream_read", rdv[c], (c >= 1 && c <= 5));
        for (int k = 0; k < 5; k++) begin
            chk("stream_valid", vv[3+k], 1);
            chk("stream_data", dv[3+k], pat[k]);
        end
        chk("stream_valid_end", vv[8], 0);
        chk("stream_cnt", s_cnt, 5);

        // backpressure
        do_reset();
        load5();
        unstable = 0;
        for (int c = 0; c < 8; c++) begin
            step(1, 0, 0);
            if (c >= 3 && (s_valid !== 1'b1 || s_data !== 8'hAA)) unstable++;
        end
        chk("bp_reads", rd_cnt, 2);
        chk("bp_valid", s_valid, 1);
        chk("bp_head", s_data, 8'hAA);
        chk("bp_stable", unstable, 0);
        for (int c = 0; c < 12; c++) step(1, 1, 0);
        chk("bp_count", got.size(), 5);
        for (int k = 0; k < 5 && k < got.size(); k++) chk("bp_order", got[k], pat[k]);
        chk("bp_reads_total", rd_cnt, 5);

        // flush
        do_reset();
        load5();
        step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        chk("flush_busy", s_busy, 1);
        for (int c = 0; c < 4; c++) step(0, 1, 0);
        chk("flush_idle", s_busy, 0);
        chk("flush_reads", rd_cnt, 2);
        chk("flush_count", got.size(), 2);
        for (int k = 0; k < 2 && k < got.size(); k++) chk("flush_order", got[k], pat[k]);
        chk("flush_left", fifo_q.size(), 3);
        if (fifo_q.size() > 0) chk("flush_left_head", fifo_q[0], 8'hCC);

        // reset mid-stream with a word buffered and one in flight
        do_reset();
        for (int k = 0; k < 8; k++) fifo_q.push_back(w8[k]);
        for (int c = 0; c < 5; c++) step(1, 1, 0);
        chk("mrst_pre_cnt", s_cnt, 1);
        step(1, 1, 1);
        step(0, 1, 0);
        chk("mrst_valid", s_valid, 0);
        chk("mrst_cnt", s_cnt, 0);
        got.delete();
        for (int c = 0; c < 12; c++) step(1, 1, 0);
        chk("mrst_count", got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++) chk("mrst_order", got[k], w8[4+k]);
        chk("mrst_cnt_end", s_cnt, 4);

        // empty boundary
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step(1, 1, 0);
            chk("empty_read", s_read, 0);
            chk("empty_valid", s_valid, 0);
        end
        chk("empty_busy", s_busy, 1);
        fifo_q.push_back(8'hA6);
        step(1, 1, 0);
        chk("empty_fall_read", s_read, 1);
        step(1, 1, 0);
        chk("empty_valid_t1", s_valid, 0);
        step(1, 1, 0);
        chk("empty_valid_t2", s_valid, 1);
        chk("empty_data_t2", s_data, 8'hA6);

        // counter wrap over 65537 words
        do_reset();
        delivered = 0; gaps = 0; pushed = 0; started = 0;
        for (int c = 0; c < 65600 && delivered < 65537; c++) begin
            while (pushed < 65537 && fifo_q.size() < 4) begin
                fifo_q.push_back(8'(pushed));
                pushed++;
            end
            step(1, 1, 0);
            if (s_valid) begin started = 1; delivered++; end
            else if (started) gaps++;
        end
        got.delete();
        step(1, 1, 0); step(1, 1, 0);
        chk("wrap_delivered", delivered, 65537);
        chk("wrap_gaps", gaps, 0);
        chk("wrap_cnt", s_cnt, 1);

        // randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 1 && fifo_q.size() < 6) fifo_q.push_back(8'($urandom));
            step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);
            if (got.size() > 64) got.delete();
        end
        step(0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
